// File: rtl/seq_signed_mac_pkg.sv
// -----------------------------------------------------------------------------
// seq_signed_mac_pkg
// Shared definitions for the sequential signed multiply-accumulate block:
// default operand/product widths and the FSM state encoding.
// Defaults are 16-bit operands and a 32-bit product; instances may override
// them through module parameters.
// -----------------------------------------------------------------------------
package seq_signed_mac_pkg;

    localparam int DEF_BIT_WIDTH    = 16;
    localparam int DEF_RESULT_WIDTH = 2 * DEF_BIT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_signed_mac_booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
// One radix-2 Booth iteration: inspects {q[0], q_m1}, adds or subtracts the
// multiplicand into the partial-product register a, then shifts
// {a, q, q_m1} right arithmetically by one bit.
// Ports:
//   a / a_next       W+1-bit partial product (one guard bit so that negating
//                    the most negative multiplicand cannot overflow)
//   q / q_next       W-bit multiplier shift register
//   q_m1 / q_m1_next Booth history bit
//   m                W+1-bit sign-extended multiplicand
// -----------------------------------------------------------------------------
module booth_step #(
  parameter int W = 16
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic         q_m1,
  input  logic [W:0]   m,
  output logic [W:0]   a_next,
  output logic [W-1:0] q_next,
  output logic         q_m1_next
);

  logic [W:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    // Arithmetic right shift of the concatenation {sum, q, q_m1}.
    a_next    = {sum[W], sum[W:1]};
    q_next    = {sum[0], q[W-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/seq_signed_mac.sv
// -----------------------------------------------------------------------------
// seq_signed_mac
// Sequential signed multiply-accumulate. An operand pair is accepted in IDLE,
// multiplied over BIT_WIDTH cycles by iterative radix-2 Booth recoding,
// accumulated in one more cycle and presented in DONE until out_ready.
// Result appears BIT_WIDTH+1 edges after the accepting edge.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      operand handshake (in_ready only in IDLE)
//   multiplicand, multiplier signed operands, BIT_WIDTH bits
//   acc_clear                captured with the operands; restart accumulation
//   out_valid / out_ready    result handshake (out_valid only in DONE)
//   product                  signed product of the last operation
//   acc                      signed running sum of products
//   acc_sat                  sticky saturation flag (SEQ_SIGNED_MAC_SATURATE_EN)
// Optional feature: define SEQ_SIGNED_MAC_SATURATE_EN to clamp acc on
// overflow and expose acc_sat; otherwise acc wraps modulo 2^ACC_WIDTH.
// -----------------------------------------------------------------------------
module seq_signed_mac
  import seq_signed_mac_pkg::*;
#(
  parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int ACC_WIDTH    = RESULT_WIDTH + 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIT_WIDTH-1:0]    multiplicand,
  input  logic [BIT_WIDTH-1:0]    multiplier,
  input  logic                    acc_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RESULT_WIDTH-1:0] product,
  output logic [ACC_WIDTH-1:0]    acc
`ifdef SEQ_SIGNED_MAC_SATURATE_EN
  ,
  output logic                    acc_sat
`endif
);

  localparam int CNT_W = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIT_WIDTH - 1);

  state_t                   state_reg;
  logic [BIT_WIDTH:0]       a_reg;
  logic [BIT_WIDTH-1:0]     q_reg;
  logic                     q_m1_reg;
  logic [BIT_WIDTH:0]       m_reg;
  logic [CNT_W-1:0]         count_reg;
  logic                     clear_reg;
  logic                     in_ready_reg;
  logic                     out_valid_reg;
  logic [RESULT_WIDTH-1:0]  product_reg;
  logic [ACC_WIDTH-1:0]     acc_reg;

  logic [BIT_WIDTH:0]       a_next;
  logic [BIT_WIDTH-1:0]     q_next;
  logic                     q_m1_next;

  logic [2*BIT_WIDTH-1:0]   full_prod;
  logic [RESULT_WIDTH-1:0]  prod_res;
  logic [ACC_WIDTH-1:0]     prod_acc;
  logic [ACC_WIDTH-1:0]     acc_base;
  logic [ACC_WIDTH-1:0]     acc_next;

  booth_step #(
    .W(BIT_WIDTH)
  ) u_booth_step (
    .a         (a_reg),
    .q         (q_reg),
    .q_m1      (q_m1_reg),
    .m         (m_reg),
    .a_next    (a_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  // After BIT_WIDTH steps the exact product sits in the low 2*BIT_WIDTH bits
  // of {a, q}; the guard bit only matters during the iterations.
  assign full_prod = {a_reg[BIT_WIDTH-1:0], q_reg};
  assign prod_res  = RESULT_WIDTH'($signed(full_prod));
  assign prod_acc  = ACC_WIDTH'($signed(prod_res));
  assign acc_base  = clear_reg ? '0 : acc_reg;

`ifdef SEQ_SIGNED_MAC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] sum_wide;
  logic               overflow;
  logic               acc_sat_reg;
  logic               acc_sat_next;

  // One extra bit detects signed overflow: the two top bits disagree.
  assign sum_wide     = {acc_base[ACC_WIDTH-1], acc_base} + {prod_acc[ACC_WIDTH-1], prod_acc};
  assign overflow     = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
  assign acc_next     = overflow ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                 : sum_wide[ACC_WIDTH-1:0];
  assign acc_sat_next = (clear_reg ? 1'b0 : acc_sat_reg) | overflow;
  assign acc_sat      = acc_sat_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sat_reg <= 1'b0;
    end else if (state_reg == ST_ACCUM) begin
      acc_sat_reg <= acc_sat_next;
    end
  end
`else
  assign acc_next = acc_base + prod_acc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      a_reg         <= '0;
      q_reg         <= '0;
      q_m1_reg      <= 1'b0;
      m_reg         <= '0;
      count_reg     <= '0;
      clear_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      product_reg   <= '0;
      acc_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= '0;
            q_reg        <= multiplier;
            q_m1_reg     <= 1'b0;
            m_reg        <= {multiplicand[BIT_WIDTH-1], multiplicand};
            count_reg    <= '0;
            clear_reg    <= acc_clear;
            in_ready_reg <= 1'b0;
            state_reg    <= ST_MULT;
          end
        end
        ST_MULT: begin
          a_reg     <= a_next;
          q_reg     <= q_next;
          q_m1_reg  <= q_m1_next;
          count_reg <= count_reg + CNT_W'(1);
          if (count_reg == LAST_STEP) begin
            state_reg <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          product_reg   <= prod_res;
          acc_reg       <= acc_next;
          out_valid_reg <= 1'b1;
          state_reg     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;
  assign acc       = acc_reg;

endmodule
